fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage of the CPU pipeline. Owns the architectural fetch PC, issues word reads to instruction memory over a request/acknowledge handshake and buffers returned instructions in a 2-entry queue toward decode. It consumes the redirect target produced by the next-PC calculation whenever a branch is taken. Each instruction is delivered together with its own PC as the `pc_in`/`inst` pair for the next-PC logic downstream.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded by reset.
- `PC_INCR`, default 4: sequential fetch increment in bytes.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `redirect` in 1: a taken branch was resolved this cycle; flush and refetch.
- `redirect_pc` in 32: new fetch PC; bits [1:0] are forced to zero.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: word-aligned fetch address.
- `imem_ack` in 1: memory accepted the request this cycle.
- `imem_rvalid` in 1: read data valid; arrives at least 1 cycle after `imem_ack`.
- `imem_rdata` in 32: instruction word.
- `out_valid` out 1: buffer head holds a valid instruction.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_pc` out 32: address of `out_inst`.
- `out_inst` out 32: instruction word.

## Operation
- States: IDLE (no request in flight), WAIT (request acked, awaiting data), DRAIN (request in flight is stale and its data must be discarded).
- Registers: `fetch_pc`; `req_pc`, the PC of the in-flight request; a 2-entry FIFO of {pc, inst}; `count` in 0..2.
- `imem_req` = (state==IDLE) && (count < 2) && !reset. `imem_addr` = `fetch_pc`. Both are driven from registered state only.
- IDLE with `imem_req` and `imem_ack`: `req_pc` <= `fetch_pc`, `fetch_pc` <= `fetch_pc` + PC_INCR (mod 2^32, wraps silently), next state WAIT. Without `imem_ack`, the request and address are held.
- WAIT with `imem_rvalid`: push {`req_pc`, `imem_rdata`}, next state IDLE. Space is guaranteed because a request is only issued when count < 2.
- DRAIN with `imem_rvalid`: the data is dropped, next state IDLE.
- Pop occurs when `out_valid && out_ready`. A push and a pop in the same cycle are allowed and leave `count` unchanged.
- Redirect has priority over all other events in the cycle:
  - FIFO cleared (count <= 0); `fetch_pc` <= {`redirect_pc`[31:2], 2'b00}.
  - Any pop in the same cycle is ignored.
  - Next state DRAIN if a request is in flight after this cycle, i.e. state WAIT without `imem_rvalid`, or IDLE with `imem_ack` in the same cycle. Otherwise the next state is IDLE; this covers WAIT/DRAIN with `imem_rvalid` in the same cycle, whose data is dropped.
  - Redirect while in DRAIN: stay in DRAIN and update `fetch_pc`.
  - A pending unacked request is withdrawn; memory must tolerate `imem_req` deasserting before ack.
- Reset: state IDLE, `fetch_pc` = RESET_PC, count = 0, `req_pc` = 0. During the reset cycle `imem_req` = 0 and `out_valid` = 0; `out_pc` and `out_inst` are don't-care while `out_valid` = 0. Reset overrides redirect and any memory response; a response arriving after reset for a pre-reset request is not supported, so memory must be reset together with this block.

## Timing
- `out_valid` = (count != 0), registered. `out_pc`/`out_inst` come from the FIFO head and stay stable while `out_valid && !out_ready`.
- With the ack in cycle T and rvalid in T+1, the instruction is at `out_valid` in T+2 (fetch-to-decode latency 2 cycles).
- Peak throughput is one instruction per 2 cycles: a single outstanding request, and a new request only from IDLE.
- After a redirect in cycle T, the first request to `redirect_pc` is issued in T+1 if no request is in flight, otherwise in the cycle after the stale response.
- No combinational path from `out_ready`, `redirect` or `imem_*` inputs to any output.

## Test plan
- Reset release with RESET_PC=0 and memory acking at once with rvalid 1 cycle later: addresses 0x0, 0x4, 0x8 issued every 2 cycles; `out_pc` = 0, 4, 8 with matching data; first `out_valid` 2 cycles after the first ack.
- Backpressure with `out_ready`=0: count reaches 2 and `imem_req` stays 0; head {0x0, data} stays stable. Raising `out_ready` resumes fetching at 0x8.
- Redirect to 0x103 while in WAIT: the stale response is dropped and the FIFO emptied. The next request goes to 0x100, and the first delivered `out_pc` is 0x100.
- Redirect in the same cycle as `imem_ack`: that response is discarded (DRAIN) and no stale instruction appears at the output. Redirect in the same cycle as `imem_rvalid`: the data is dropped and the state returns to IDLE.
- `fetch_pc` = 0xFFFF_FFFC: next request wraps to 0x0000_0000. Reset asserted mid-WAIT: next cycle `out_valid`=0, state IDLE, request to RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch with single outstanding request and 2-entry
//            {pc, inst} queue toward decode; redirects flush and refetch.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INCR  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam logic [31:0] C_PC_INCR = 32'(PC_INCR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_fifo_pc   [2];
    logic [31:0] r_fifo_inst [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_req;
    logic        w_acked;
    logic        w_push;
    logic        w_pop;
    logic        w_in_flight;
    logic        w_unused;

    // Low redirect bits are discarded by the word alignment.
    assign w_unused = &{1'b0, redirect_pc[1:0]};

    assign w_req   = (r_state == S_IDLE) && (r_count < 2'd2) && !reset;
    assign w_acked = w_req && imem_ack;
    assign w_push  = (r_state == S_WAIT) && imem_rvalid;
    assign w_pop   = out_valid && out_ready;

    // A request is still outstanding after this cycle unless its data returns now.
    assign w_in_flight = w_acked
                      || (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !imem_rvalid);

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;
    assign out_valid = (r_count != 2'd0) && !reset;
    assign out_pc    = r_fifo_pc[r_rd_ptr];
    assign out_inst  = r_fifo_inst[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= 32'h0000_0000;
            r_count    <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
        end else if (redirect) begin
            r_count    <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_state    <= w_in_flight ? S_DRAIN : S_IDLE;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 2'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_acked) begin
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + C_PC_INCR;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (!reset && !redirect && w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_req_pc;
            r_fifo_inst[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire
